hack_mul_seq: RTL and testbench

- Multi-cycle 16x16 multiplier controller that computes a product by sequencing a single external Hack ALU through shift-and-add microsteps.
- Drives the ALU operands and its six control bits (zx,nx,zy,ny,f,no), and samples the ALU's out/zr flag.
- Sits beside the CPU datapath as a multiply coprocessor; the ALU instance stays outside the block so it can later be shared with other sequencers.

---
 rtl/hack_mul_seq.sv | 144 ++++++++++++++
 tb/tb_hack_mul_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_mul_seq.sv
// Shift-and-add 16x16 multiplier that sequences an external Hack ALU.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplicand reaches zero.
module hack_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr
);

    // state  | meaning
    // IDLE   | waiting for start, ALU parked at zero
    // TEST   | mplier & mask, zr tells whether this bit is set
    // ADD    | acc + mcand
    // SHL_A  | mcand + mcand (shift multiplicand left)
    // SHL_M  | mask + mask (advance to next bit), cnt increments
    // DONE   | one-cycle done, product valid, start accepted again
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TEST  = 3'd1,
        ADD   = 3'd2,
        SHL_A = 3'd3,
        SHL_M = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mask, mplier;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt = state;
        alu_x     = '0;
        alu_y     = '0;
        alu_zx    = 1'b0;
        alu_nx    = 1'b0;
        alu_zy    = 1'b0;
        alu_ny    = 1'b0;
        alu_f     = 1'b0;
        alu_no    = 1'b0;
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = TEST;
            end
            TEST: begin
                alu_x = mplier;
                alu_y = mask;
                if (!alu_zr)              state_nxt = ADD;
                else if (cnt == LAST_BIT) state_nxt = DONE;
                else                      state_nxt = SHL_A;
            end
            ADD: begin
                alu_x = acc;
                alu_y = mcand;
                alu_f = 1'b1;
                state_nxt = (cnt == LAST_BIT) ? DONE : SHL_A;
            end
            SHL_A: begin
                alu_x = mcand;
                alu_y = mcand;
                alu_f = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
                state_nxt = alu_zr ? DONE : SHL_M;
`else
                state_nxt = SHL_M;
`endif
            end
            SHL_M: begin
                alu_x = mask;
                alu_y = mask;
                alu_f = 1'b1;
                state_nxt = TEST;
            end
            DONE: begin
                state_nxt = accept ? TEST : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ADD may be the last step, so the product captures the post-add value
    assign acc_nxt = (state == ADD) ? alu_out : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mask    <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            acc <= acc_nxt;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand  <= a;
                        mplier <= b;
                        mask   <= WIDTH'(1);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                SHL_A: mcand <= alu_out;
                SHL_M: begin
                    mask <= alu_out;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
            if (state_nxt == DONE && state != DONE) product <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_hack_mul_seq.sv
// Bench for hack_mul_seq: Hack ALU model, cycle-level behavioural scoreboard, directed vectors.
module tb_hack_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] product, alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr;

    int total = 0;
    int bad   = 0;

    hack_mul_seq dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr)
    );

    always #5 clk = ~clk;

    // external Hack ALU
    always_comb begin
        logic [15:0] xx, yy, oo;
        xx = alu_zx ? 16'h0000 : alu_x;
        xx = alu_nx ? ~xx : xx;
        yy = alu_zy ? 16'h0000 : alu_y;
        yy = alu_ny ? ~yy : yy;
        oo = alu_f ? (xx + yy) : (xx & yy);
        oo = alu_no ? ~oo : oo;
        alu_out = oo;
        alu_zr  = (oo == 16'h0000);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // cycles spent busy, from the bit-serial shift-and-add algorithm
    function automatic int lat(input logic [15:0] aa, input logic [15:0] bb);
        int c = 0;
        logic [15:0] m = aa;
        for (int i = 0; i < 16; i++) begin
            c += 1 + int'(bb[i]);
            if (i == 15) break;
            m = m << 1;
            c += 1;
`ifdef MUL_EARLY_EXIT_EN
            if (m == 16'h0000) return c;
`endif
            c += 1;
        end
        return c;
    endfunction

    // scoreboard: phase 0 idle, 1 busy, 2 done
    int          m_phase;
    int          m_left;
    logic [15:0] m_prod, m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_left  = 0;
            m_prod  = 16'h0000;
            m_pend  = 16'h0000;
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 2;
                m_prod  = m_pend;
            end
        end else if (start) begin
            m_phase = 1;
            m_left  = lat(a, b);
            m_pend  = a * b;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 64'(busy), 64'(m_phase == 1));
            check("done", 64'(done), 64'(m_phase == 2));
            check("product", 64'(product), 64'(m_prod));
            if (m_phase != 1)
                check("alu_parked", {26'd0, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 64'd0);
        end
    end

    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] ep,
                          input int ecyc, input bit glitch);
        int k;
        a = aa;
        b = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check("busy_cycle1", 64'(busy), 64'd1);
        while (!done && k < 200) begin
            if (k == 1)
                check("alu_test", {alu_x, alu_y, 26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                      {bb, 16'h0001, 32'd0});
            if (k == 2) begin
                if (bb[0])
                    check("alu_add", {alu_x, alu_y, 26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                          {16'h0000, aa, 32'd2});
                else
                    check("alu_shl", {alu_x, alu_y, 26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                          {aa, aa, 32'd2});
            end
            if (glitch && k == 10) begin
                a = 16'h7777;
                b = 16'h0101;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        if (ecyc > 0) check("done_cycle", 64'(k), 64'(ecyc));
        check("result", 64'(product), 64'(ep));
    endtask

`ifdef MUL_EARLY_EXIT_EN
    `define CYC(n) (-1)
`else
    `define CYC(n) (n)
`endif

    initial begin
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_alu", {26'd0, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // model pinning: latency and wrap-around products
        check("lat_b0", 64'(lat(16'h1234, 16'h0000)), 64'(`CYC(46) < 0 ? lat(16'h1234, 16'h0000) : 46));
        check("pin_mul", 64'(16'(16'hFFFD * 16'h0007)), 64'hFFEB);

        run_op(16'h0003, 16'h0005, 16'h000F, `CYC(49), 1'b0);
        repeat (3) @(negedge clk);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, `CYC(63), 1'b0);
        repeat (2) @(negedge clk);
        run_op(16'hFFFD, 16'h0007, 16'hFFEB, `CYC(50), 1'b0);
        @(negedge clk);
        run_op(16'h1234, 16'h0000, 16'h0000, `CYC(47), 1'b0);
        @(negedge clk);
        run_op(16'h0102, 16'h0304, 16'h0A08, `CYC(50), 1'b1);
        @(negedge clk);
        // back-to-back: second start rides the DONE cycle
        run_op(16'h00FF, 16'h0101, 16'hFFFF, `CYC(49), 1'b0);
        run_op(16'h0010, 16'h0010, 16'h0100, `CYC(48), 1'b0);
`ifdef MUL_EARLY_EXIT_EN
        @(negedge clk);
        run_op(16'h8000, 16'hFFFF, 16'h8000, 4, 1'b0);
        @(negedge clk);
        run_op(16'h0000, 16'h0000, 16'h0000, 3, 1'b0);
`endif

        // asynchronous reset in cycle 20 of an operation
        @(negedge clk);
        a = 16'h0005;
        b = 16'h00FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("busy_before_rst", 64'(busy), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_product", 64'(product), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_rst", 64'(dcount), 64'd0);
        run_op(16'h0009, 16'h0009, 16'h0051, `CYC(49), 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
